// File: rtl/rotary_quad_gen.sv
`default_nettype none
// ============================================================================
// Module      : rotary_quad_gen
// Description : Quadrature rotary-encoder emulator; replays direction/detent
//               and button commands as Rot_A/Rot_B/Rot_C waveforms.
//               Optional contact bounce on S1/BTN entry: define ROT_BOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rotary_quad_gen #(
    parameter int PHASE_CYC = 16,
    parameter int GAP_CYC   = 32,
    parameter int BTN_CYC   = 4
) (
    input  logic               Fg_CLK,
    input  logic               RESET,
    input  logic               Cmd_Valid,
    output logic               Cmd_Ready,
    input  logic               Cmd_Dir,
    input  logic [7:0]         Cmd_Cnt,
    input  logic               Cmd_Btn,
    output logic               Rot_A,
    output logic               Rot_B,
    output logic               Rot_C,
    output logic               Busy,
    output logic               Done,
    output logic signed [11:0] Pos
);

    localparam logic [15:0] c_phase_ld = 16'(PHASE_CYC - 1);
    localparam logic [15:0] c_gap_ld   = 16'(GAP_CYC - 1);
    localparam logic [15:0] c_btn_ld   = 16'(BTN_CYC - 1);

    // ARM is a one-cycle launch state so the first line change lands after T+1
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
        GAP  = 3'd5,
        BTN  = 3'd6,
        FIN  = 3'd7
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [7:0]  r_left;
    logic        r_dir;
    logic        r_btn;
    logic        r_a;
    logic        r_b;
    logic        r_c;
    logic [11:0] r_pos;
    logic        w_accept;
    logic        w_cnt_zero;

    assign Cmd_Ready  = (r_state == IDLE) & ~RESET;
    assign w_accept   = Cmd_Valid & Cmd_Ready;
    assign w_cnt_zero = (r_cnt == 16'd0);

    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_left  <= 8'd0;
            r_dir   <= 1'b0;
            r_btn   <= 1'b0;
            r_a     <= 1'b1;
            r_b     <= 1'b1;
            r_c     <= 1'b0;
            r_pos   <= 12'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= ARM;
                        r_dir   <= Cmd_Dir;
                        r_btn   <= Cmd_Btn;
                        r_left  <= Cmd_Cnt;
                    end
                end
                ARM: begin
                    if (r_btn) begin
                        r_state <= BTN;
                        r_cnt   <= c_btn_ld;
                        r_c     <= 1'b1;
                    end else if (r_left == 8'd0) begin
                        r_state <= FIN;
                    end else begin
                        r_state <= S1;
                        r_cnt   <= c_phase_ld;
                        r_a     <= r_dir;
                        r_b     <= ~r_dir;
                    end
                end
                S1: begin
`ifdef ROT_BOUNCE_EN
                    // falling line: low, high, then low for the rest of S1
                    if (r_dir) r_b <= (r_cnt == c_phase_ld);
                    else       r_a <= (r_cnt == c_phase_ld);
`endif
                    if (w_cnt_zero) begin
                        r_state <= S2;
                        r_cnt   <= c_phase_ld;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S2: begin
                    if (w_cnt_zero) begin
                        r_state <= S3;
                        r_cnt   <= c_phase_ld;
                        r_a     <= ~r_dir;
                        r_b     <= r_dir;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S3: begin
                    if (w_cnt_zero) begin
                        r_state <= GAP;
                        r_cnt   <= c_gap_ld;
                        r_a     <= 1'b1;
                        r_b     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                GAP: begin
                    if (w_cnt_zero) begin
                        r_pos  <= r_dir ? (r_pos + 12'd1) : (r_pos - 12'd1);
                        r_left <= r_left - 8'd1;
                        if (r_left == 8'd1) begin
                            r_state <= FIN;
                        end else begin
                            r_state <= S1;
                            r_cnt   <= c_phase_ld;
                            r_a     <= r_dir;
                            r_b     <= ~r_dir;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                BTN: begin
`ifdef ROT_BOUNCE_EN
                    r_c <= (r_cnt != c_btn_ld);
`endif
                    if (w_cnt_zero) begin
                        r_state <= FIN;
                        r_c     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Rot_A = r_a;
    assign Rot_B = r_b;
    assign Rot_C = r_c;
    assign Busy  = (r_state != IDLE) && (r_state != FIN);
    assign Done  = (r_state == FIN);
    assign Pos   = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_rotary_quad_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotary_quad_gen
// Description : Scoreboard bench for rotary_quad_gen with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotary_quad_gen;

    localparam int P  = 16;
    localparam int G  = 32;
    localparam int BT = 4;
    localparam int D  = 3 * P + G;

    logic               clk = 1'b0;
    logic               RESET = 1'b1;
    logic               Cmd_Valid = 1'b0;
    logic               Cmd_Ready;
    logic               Cmd_Dir = 1'b0;
    logic [7:0]         Cmd_Cnt = 8'd0;
    logic               Cmd_Btn = 1'b0;
    logic               Rot_A;
    logic               Rot_B;
    logic               Rot_C;
    logic               Busy;
    logic               Done;
    logic signed [11:0] Pos;

    rotary_quad_gen #(.PHASE_CYC(P), .GAP_CYC(G), .BTN_CYC(BT)) dut (
        .Fg_CLK   (clk),
        .RESET    (RESET),
        .Cmd_Valid(Cmd_Valid),
        .Cmd_Ready(Cmd_Ready),
        .Cmd_Dir  (Cmd_Dir),
        .Cmd_Cnt  (Cmd_Cnt),
        .Cmd_Btn  (Cmd_Btn),
        .Rot_A    (Rot_A),
        .Rot_B    (Rot_B),
        .Rot_C    (Rot_C),
        .Busy     (Busy),
        .Done     (Done),
        .Pos      (Pos)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int  t;
        bit  btn;
        bit  dir;
        int  cnt;
        int  done_k;
        int  pos;
    } cmd_t;

    cmd_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_pos   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {A,B,C} k cycles after the accept edge, from the detent timeline
    function automatic logic [2:0] exp_lines(input cmd_t c, input int k);
        int r;
        logic a, b, cc;
        a = 1'b1; b = 1'b1; cc = 1'b0;
        if (c.btn) begin
            cc = (k >= 1 && k <= BT);
`ifdef ROT_BOUNCE_EN
            if (k == 2) cc = 1'b0;
`endif
        end else if (k >= 1 && k <= c.cnt * D) begin
            r = (k - 1) % D;
            if (r < P) begin
                a = c.dir; b = ~c.dir;
`ifdef ROT_BOUNCE_EN
                if (r == 1) begin a = 1'b1; b = 1'b1; end
`endif
            end else if (r < 2 * P) begin
                a = 1'b0; b = 1'b0;
            end else if (r < 3 * P) begin
                a = ~c.dir; b = c.dir;
            end
        end
        return {a, b, cc};
    endfunction

    // Monitor: per-cycle line/handshake checks, scored as one comparison per command
    int line_err = 0;
    initial begin : monitor
        int k;
        logic [2:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (RESET) begin
                q.delete();
                line_err = 0;
                continue;
            end
            k = 0;
            if (q.size() > 0) begin
                k = cyc - q[0].t;
                e = exp_lines(q[0], k);
                if ({Rot_A, Rot_B, Rot_C} !== e) line_err++;
                if (Cmd_Ready !== 1'b0) line_err++;
                if (k >= 1 && Busy !== (k < q[0].done_k)) line_err++;
            end else if ({Rot_A, Rot_B, Rot_C} !== 3'b110 || Busy !== 1'b0) begin
                chk("idle_lines", {Rot_A, Rot_B, Rot_C, Busy}, 4'b1100);
            end
            if (Done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    chk("done_latency", k, q[0].done_k);
                    chk("pos_at_done", int'($unsigned(Pos)), q[0].pos);
                    chk("waveform_errors", line_err, 0);
                    void'(q.pop_front());
                    line_err = 0;
                end
            end else if (q.size() > 0 && k > q[0].done_k) begin
                chk("done_missing", k, q[0].done_k);
                void'(q.pop_front());
                line_err = 0;
            end
        end
    end

    // Issue a command; pushes the expected response at the accept edge
    task automatic send(input bit btn, input bit dir, input int cnt, input bit hold);
        cmd_t c;
        int   w;
        bit   ok;
        Cmd_Valid = 1'b1;
        Cmd_Btn   = btn;
        Cmd_Dir   = dir;
        Cmd_Cnt   = 8'(cnt);
        ok = 1'b0;
        for (w = 0; w < 5000; w++) begin
            if (Cmd_Ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("ready_timeout", 0, 1);
            Cmd_Valid = 1'b0;
            return;
        end
        @(negedge clk);
        c.t   = cyc;
        c.btn = btn;
        c.dir = dir;
        c.cnt = btn ? 0 : cnt;
        if (btn) c.done_k = 1 + BT;
        else     c.done_k = 1 + cnt * D;
        if (!btn) m_pos = dir ? m_pos + cnt : m_pos - cnt;
        c.pos = m_pos & 12'hFFF;
        q.push_back(c);
        // scramble inputs to confirm they were latched at accept
        Cmd_Dir = 1'($urandom);
        Cmd_Cnt = 8'($urandom);
        Cmd_Btn = 1'($urandom);
        if (hold) begin
            for (w = 0; w < 5000 && q.size() > 0; w++) begin
                @(negedge clk);
                #2;
            end
        end
        Cmd_Valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        for (w = 0; w < 5000 && q.size() > 0; w++) @(negedge clk);
        chk("drain_queue", q.size(), 0);
        @(negedge clk);
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_rot_a", Rot_A, 1);
        chk("rst_rot_b", Rot_B, 1);
        chk("rst_rot_c", Rot_C, 0);
        chk("rst_ready", Cmd_Ready, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_pos", int'($unsigned(Pos)), 0);

        send(1'b0, 1'b1, 3, 1'b1);
        wait_idle();
        chk("pos_after_up3", int'($unsigned(Pos)), 3);
        send(1'b0, 1'b0, 2, 1'b0);
        wait_idle();
        send(1'b0, 1'b0, 3, 1'b0);
        wait_idle();
        chk("pos_after_down", int'($unsigned(Pos)), 12'hFFE);
        send(1'b0, 1'b1, 0, 1'b0);
        wait_idle();
        chk("pos_after_cnt0", int'($unsigned(Pos)), 12'hFFE);
        send(1'b1, 1'b0, 7, 1'b0);
        wait_idle();

        for (int i = 0; i < 20; i++) begin
            int r;
            r = int'($urandom_range(0, 5));
            send(r == 0, 1'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // reset mid-command aborts with idle lines and cleared position
        send(1'b0, 1'b1, 5, 1'b0);
        repeat (99) @(negedge clk);
        RESET = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rot_a", Rot_A, 1);
        chk("abort_rot_b", Rot_B, 1);
        chk("abort_rot_c", Rot_C, 0);
        chk("abort_pos", int'($unsigned(Pos)), 0);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_ready_in_rst", Cmd_Ready, 0);
        m_pos = 0;
        @(negedge clk);
        RESET = 1'b0;
        #1;
        chk("ready_after_rst", Cmd_Ready, 1);
        send(1'b0, 1'b0, 1, 1'b0);
        wait_idle();
        chk("pos_after_rst_down1", int'($unsigned(Pos)), 12'hFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
